// File: rtl/showdown_sequencer_pkg.sv
// Shared types for the showdown sequencer: FSM encoding, hand categories, score width
// and the player-count clamp used at request acceptance.
package showdown_sequencer_pkg;

    localparam int SCORE_W = 15;

    localparam logic [2:0] CAT_NONE     = 3'd0;
    localparam logic [2:0] CAT_PAIR     = 3'd1;
    localparam logic [2:0] CAT_TWO_PAIR = 3'd2;
    localparam logic [2:0] CAT_THREE    = 3'd3;
    localparam logic [2:0] CAT_FULL     = 3'd4;
    localparam logic [2:0] CAT_FOUR     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ACT, S_WAIT, S_CAPTURE, S_NEXT, S_DONE
    } state_e;

    typedef logic [SCORE_W-1:0] score_t;

    function automatic logic [2:0] clamp_players(input logic [2:0] n, input int max_p);
        if (n < 3'd2) return 3'd2;
        if (int'(n) > max_p) return 3'(max_p);
        return n;
    endfunction

endpackage

// File: rtl/showdown_sequencer_if.sv
// Request, evaluator and result signals of the showdown sequencer.
// slave = sequencer view, master = requester/evaluator view.
interface showdown_sequencer_if #(parameter int MAX_PLAYERS = 4);
    import showdown_sequencer_pkg::*;

    logic                     start;
    logic [2:0]               num_players;
    logic [8*MAX_PLAYERS-1:0] hole_cards;
    logic [19:0]              community_cards;
    logic [27:0]              eval_card;
    logic                     eval_activate;
    logic [4:0]               eval_flags;
    logic [11:0]              eval_max;
    logic                     busy;
    logic                     done;
    logic [MAX_PLAYERS-1:0]   winner_mask;
    score_t                   best_score;

    modport slave (
        input  start, num_players, hole_cards, community_cards, eval_flags, eval_max,
        output eval_card, eval_activate, busy, done, winner_mask, best_score
    );

    modport master (
        output start, num_players, hole_cards, community_cards, eval_flags, eval_max,
        input  eval_card, eval_activate, busy, done, winner_mask, best_score
    );

endinterface

// File: rtl/showdown_sequencer_score_encoder.sv
// Combinational hand score: priority-encoded category on top of the evaluator's three max ranks.
module score_encoder
    import showdown_sequencer_pkg::*;
(
    input  logic [4:0]  eval_flags_i,
    input  logic [11:0] eval_max_i,
    output score_t      score_o
);

    logic [2:0] cat;

    always_comb begin
        cat = CAT_NONE;
        if      (eval_flags_i[4]) cat = CAT_FOUR;
        else if (eval_flags_i[3]) cat = CAT_FULL;
        else if (eval_flags_i[2]) cat = CAT_THREE;
        else if (eval_flags_i[1]) cat = CAT_TWO_PAIR;
        else if (eval_flags_i[0]) cat = CAT_PAIR;
    end

    assign score_o = {cat, eval_max_i};

endmodule

// File: rtl/showdown_sequencer.sv
// Steps each active player's seven cards through an external evaluator and tracks the best score
// and the set of players holding it; done pulses N*(EVAL_WAIT+3)+1 cycles after start is accepted.
module showdown_sequencer
    import showdown_sequencer_pkg::*;
#(
    parameter int MAX_PLAYERS = 4,
    parameter int EVAL_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    showdown_sequencer_if.slave   bus
);

    state_e                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             nplay_q, nplay_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [27:0]            card_q, card_d;
    score_t                 best_q, best_d;
    logic [MAX_PLAYERS-1:0] mask_q, mask_d;

    score_t                 score;
    logic [7:0]             hole_sel;
    logic [MAX_PLAYERS-1:0] idx_onehot;

    score_encoder u_score_encoder (
        .eval_flags_i (bus.eval_flags),
        .eval_max_i   (bus.eval_max),
        .score_o      (score)
    );

    assign hole_sel   = bus.hole_cards[8*idx_q[1:0] +: 8];
    assign idx_onehot = MAX_PLAYERS'(1) << idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            nplay_q <= '0;
            cnt_q   <= '0;
            card_q  <= '0;
            best_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nplay_q <= nplay_d;
            cnt_q   <= cnt_d;
            card_q  <= card_d;
            best_q  <= best_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nplay_d = nplay_q;
        cnt_d   = cnt_q;
        card_d  = card_q;
        best_d  = best_q;
        mask_d  = mask_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    cnt_d   = '0;
                    best_d  = '0;
                    mask_d  = '0;
                    nplay_d = clamp_players(bus.num_players, MAX_PLAYERS);
                end
            end
            S_LOAD: begin
                card_d  = {bus.community_cards, hole_sel};
                state_d = S_ACT;
            end
            // The capture edge itself is the last of the EVAL_WAIT cycles after the
            // activate edge, so WAIT only covers the EVAL_WAIT-1 cycles before it.
            S_ACT: begin
                cnt_d   = 4'(EVAL_WAIT - 1);
                state_d = (EVAL_WAIT > 1) ? S_WAIT : S_CAPTURE;
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                if (idx_q == 3'd0 || score > best_q) begin
                    best_d = score;
                    mask_d = idx_onehot;
                end else if (score == best_q) begin
                    mask_d = mask_q | idx_onehot;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == nplay_q - 3'd1) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.eval_card     = card_q;
    assign bus.eval_activate = (state_q == S_ACT);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.winner_mask   = mask_q;
    assign bus.best_score    = best_q;

endmodule
